// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution dot-product engine.
package conv_pkg;

    typedef enum logic [1:0] {
        W_EMPTY = 2'd0,
        W_LOAD  = 2'd1,
        READY   = 2'd2,
        ACCUM   = 2'd3
    } conv_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Group sum width that cannot overflow for up to mb tiles.
    function automatic int conv_ow(input int dw, input int ww, input int ch, input int k, input int mb);
        return dw + ww + clog2(ch * k) + clog2(mb);
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One channel of the dot product: K products registered (E1), then their sum registered (E2).
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter  int K  = 16,
    parameter  int DW = 4,
    parameter  int WW = 4,
    localparam int SW = DW + WW + clog2(K)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [K*DW-1:0] x,
    input  logic [K*WW-1:0] w,
    output logic [SW-1:0]   sum
);

    localparam int PW = DW + WW;

    logic [PW-1:0] prod_d [K];
    logic [PW-1:0] prod_q [K];
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;

    always_comb begin
        for (int e = 0; e < K; e++) begin
            prod_d[e] = PW'(x[e*DW +: DW]) * PW'(w[e*WW +: WW]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int e = 0; e < K; e++) begin
            sum_d = sum_d + SW'(prod_q[e]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < K; e++) prod_q[e] <= '0;
            sum_q <= '0;
        end else begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/conv_dot_engine.sv
// Multi-channel dot-product engine with loadable weights and per-group accumulation.
// Build option: define CONV_SAT_EN for a clamping accumulator and the out_sat port.
module conv_dot_engine
    import conv_pkg::*;
#(
    parameter  int CH        = 2,
    parameter  int K         = 16,
    parameter  int DW        = 4,
    parameter  int WW        = 4,
    parameter  int MAX_BEATS = 4,
    localparam int OW        = conv_ow(DW, WW, CH, K, MAX_BEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [K*WW-1:0]    w_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [CH*K*DW-1:0] in_data,
    output logic [1:0]         dbg_state,
    output logic               out_valid,
    output logic [OW-1:0]      out_ofm
`ifdef CONV_SAT_EN
    ,
    output logic               out_sat
`endif
);

    localparam int IW = (CH > 1) ? clog2(CH) : 1;
    localparam int SW = DW + WW + clog2(K);

    localparam logic [1:0] ST_W_EMPTY = W_EMPTY;
    localparam logic [1:0] ST_W_LOAD  = W_LOAD;
    localparam logic [1:0] ST_READY   = READY;
    localparam logic [1:0] ST_ACCUM   = ACCUM;

    logic [1:0]          state_d, state_q;
    logic [IW-1:0]       w_idx_d, w_idx_q;
    logic [K*WW-1:0]     weights_d [CH];
    logic [K*WW-1:0]     weights_q [CH];
    logic [CH*K*DW-1:0]  tile_d, tile_q;
    logic                v0_d, v0_q, l0_d, l0_q;
    logic                v1_d, v1_q, l1_d, l1_q;
    logic                v2_d, v2_q, l2_d, l2_q;
    logic [OW-1:0]       acc_d, acc_q;
    logic                out_valid_d, out_valid_q;
    logic [OW-1:0]       out_ofm_d, out_ofm_q;
    logic [SW-1:0]       lane_sum [CH];
    logic [OW-1:0]       tile_sum;
    logic [OW-1:0]       acc_next;
    logic                w_accept, in_accept, pipe_busy;

    // Handshakes: a beat transfers on the rising edge where valid && ready.
    // A tile offered in READY takes priority over a concurrent weight beat.
    assign pipe_busy = v0_q | v1_q | v2_q;
    assign in_ready  = (state_q == ST_READY) || (state_q == ST_ACCUM);
    assign w_ready   = (state_q != ST_ACCUM) && !pipe_busy
                       && !((state_q == ST_READY) && in_valid);
    assign w_accept  = w_valid && w_ready;
    assign in_accept = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        w_idx_d   = w_idx_q;
        weights_d = weights_q;
        if (w_accept) begin
            weights_d[w_idx_q] = w_data;
            if (w_idx_q == IW'(CH - 1)) begin
                w_idx_d = '0;
                state_d = ST_READY;
            end else begin
                w_idx_d = w_idx_q + IW'(1);
                state_d = ST_W_LOAD;
            end
        end else if (in_accept) begin
            if (state_q == ST_READY && !in_last)     state_d = ST_ACCUM;
            else if (state_q == ST_ACCUM && in_last) state_d = ST_READY;
        end
    end

    always_comb begin
        tile_d = in_accept ? in_data : tile_q;
        v0_d   = in_accept;
        l0_d   = in_accept && in_last;
        v1_d   = v0_q;
        l1_d   = l0_q;
        v2_d   = v1_q;
        l2_d   = l1_q;
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        conv_mac_lane #(.K(K), .DW(DW), .WW(WW)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (tile_q[c*K*DW +: K*DW]),
            .w     (weights_q[c]),
            .sum   (lane_sum[c])
        );
    end

    always_comb begin
        tile_sum = '0;
        for (int c = 0; c < CH; c++) begin
            tile_sum = tile_sum + OW'(lane_sum[c]);
        end
    end

`ifdef CONV_SAT_EN
    logic [OW:0] sum_ext;
    logic        ovf;
    logic        sat_d, sat_q, out_sat_d, out_sat_q;

    always_comb begin
        sum_ext  = {1'b0, acc_q} + {1'b0, tile_sum};
        ovf      = sum_ext[OW];
        acc_next = ovf ? '1 : sum_ext[OW-1:0];
    end
`else
    assign acc_next = acc_q + tile_sum;
`endif

    // The accumulator clears on the last tile so the next group can start immediately.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_ofm_d   = '0;
`ifdef CONV_SAT_EN
        sat_d       = sat_q;
        out_sat_d   = 1'b0;
`endif
        if (v2_q) begin
            if (l2_q) begin
                acc_d       = '0;
                out_valid_d = 1'b1;
                out_ofm_d   = acc_next;
`ifdef CONV_SAT_EN
                out_sat_d   = sat_q | ovf;
                sat_d       = 1'b0;
`endif
            end else begin
                acc_d = acc_next;
`ifdef CONV_SAT_EN
                sat_d = sat_q | ovf;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_W_EMPTY;
            w_idx_q     <= '0;
            for (int c = 0; c < CH; c++) weights_q[c] <= '0;
            tile_q      <= '0;
            v0_q        <= 1'b0;
            l0_q        <= 1'b0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_ofm_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_idx_q     <= w_idx_d;
            weights_q   <= weights_d;
            tile_q      <= tile_d;
            v0_q        <= v0_d;
            l0_q        <= l0_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            v2_q        <= v2_d;
            l2_q        <= l2_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ofm_q   <= out_ofm_d;
        end
    end

`ifdef CONV_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`endif

    assign dbg_state = state_q;
    assign out_valid = out_valid_q;
    assign out_ofm   = out_ofm_q;

endmodule

// File: tb/tb_conv_dot_engine.sv
// Directed self-checking bench for conv_dot_engine at default parameters.
module tb_conv_dot_engine;

    localparam int CH = 2;
    localparam int K  = 16;
    localparam int DW = 4;
    localparam int WW = 4;
    localparam int OW = 15;

    localparam int ST_W_EMPTY = 0;
    localparam int ST_W_LOAD  = 1;
    localparam int ST_READY   = 2;
    localparam int ST_ACCUM   = 3;

    logic               clk;
    logic               rst_n;
    logic               w_valid;
    logic               w_ready;
    logic [K*WW-1:0]    w_data;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [CH*K*DW-1:0] in_data;
    logic [1:0]         dbg_state;
    logic               out_valid;
    logic [OW-1:0]      out_ofm;
`ifdef CONV_SAT_EN
    logic               out_sat;
`endif

    conv_dot_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .dbg_state (dbg_state),
        .out_valid (out_valid),
        .out_ofm   (out_ofm)
`ifdef CONV_SAT_EN
        ,
        .out_sat   (out_sat)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int n_out      = 0;
    int unexpected = 0;
    int acc_cyc    = 0;
    int out_cyc_q[$];
    logic [OW-1:0] exp_q[$];
    logic          exp_sat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // scoreboard: every result strobe is matched against the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                n_out++;
                out_cyc_q.push_back(cyc);
                if (exp_q.size() > 0) begin
                    check("ofm", 32'(out_ofm), 32'(exp_q.pop_front()));
`ifdef CONV_SAT_EN
                    check("sat", 32'(out_sat), 32'(exp_sat_q.pop_front()));
`endif
                end else begin
                    unexpected++;
                end
            end else begin
                check("ofm_idle", 32'(out_ofm), 32'd0);
            end
        end
    end

    // driver tasks
    task automatic load_beat(input logic [WW-1:0] v);
        logic ok;
        ok      = 1'b0;
        w_valid = 1'b1;
        w_data  = {K{v}};
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = w_ready;
            @(posedge clk); #1;
        end
        check("w_accept", 32'(ok), 32'd1);
    endtask

    task automatic load_weights(input logic [WW-1:0] v);
        for (int c = 0; c < CH; c++) load_beat(v);
        w_valid = 1'b0;
    endtask

    task automatic send_tile(input logic [DW-1:0] v, input logic last);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = {(CH*K){v}};
        in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        check("in_accept", 32'(ok), 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic push_exp(input logic [OW-1:0] v, input logic s);
        exp_q.push_back(v);
        exp_sat_q.push_back(s);
    endtask

    task automatic wait_outs(input int target);
        for (int i = 0; i < 30 && n_out < target; i++) begin
            @(posedge clk); #1;
        end
        check("out_count", 32'(n_out), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_ofm"}, 32'(out_ofm), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_w_ready"}, 32'(w_ready), 32'd1);
        check({tag, "_state"}, 32'(dbg_state), ST_W_EMPTY);
`ifdef CONV_SAT_EN
        check({tag, "_out_sat"}, 32'(out_sat), 32'd0);
`endif
    endtask

    int base;

    initial begin
        rst_n    = 1'b0;
        w_valid  = 1'b0;
        w_data   = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // tiles offered in W_EMPTY are refused
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = {(CH*K){4'd1}};
        #1;
        check("in_ready_empty", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;

        // first weight beat, then a tile offer while mid-load
        load_beat(4'd1);
        w_valid = 1'b0;
        check("state_wload", 32'(dbg_state), ST_W_LOAD);
        in_valid = 1'b1;
        #1;
        check("in_ready_wload", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        load_beat(4'd1);
        w_valid = 1'b0;
        check("state_ready", 32'(dbg_state), ST_READY);
        repeat (4) @(posedge clk);
        #1;
        check("no_out_before_tiles", 32'(n_out), 32'd0);

        // smoke: 32 ones times ones
        base = n_out;
        push_exp(15'd32, 1'b0);
        send_tile(4'd1, 1'b1);
        in_valid = 1'b0;
        wait_outs(base + 1);
        check("smoke_latency", 32'(out_cyc_q[$] - acc_cyc), 32'd3);

        // maximum group with a weight offer during ACCUM, then a back-to-back single tile
        load_weights(4'd15);
        base = n_out;
        push_exp(15'd28800, 1'b0);
        push_exp(15'd480, 1'b0);
        send_tile(4'd15, 1'b0);
        check("state_accum", 32'(dbg_state), ST_ACCUM);
        w_valid = 1'b1;
        w_data  = {K{4'd7}};
        #1;
        check("w_ready_accum", 32'(w_ready), 32'd0);
        send_tile(4'd15, 1'b0);
        send_tile(4'd15, 1'b0);
        w_valid = 1'b0;
        send_tile(4'd15, 1'b1);
        check("state_after_last", 32'(dbg_state), ST_READY);
        send_tile(4'd1, 1'b1);
        in_valid = 1'b0;
        wait_outs(base + 2);
        check("b2b_gap", 32'(out_cyc_q[$] - out_cyc_q[$-1]), 32'd1);

        // overflow: five full tiles
        base = n_out;
`ifdef CONV_SAT_EN
        push_exp(15'd32767, 1'b1);
`else
        push_exp(15'd3232, 1'b0);
`endif
        for (int t = 0; t < 4; t++) send_tile(4'd15, 1'b0);
        send_tile(4'd15, 1'b1);
        in_valid = 1'b0;
        wait_outs(base + 1);

        // reset in the middle of a group
        base = n_out;
        send_tile(4'd15, 1'b0);
        send_tile(4'd15, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd0);
        repeat (6) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("no_out_after_rst", 32'(n_out), 32'(base));

        // reload and run a two-tile mixed group: 64 + 32
        load_weights(4'd1);
        push_exp(15'd96, 1'b0);
        send_tile(4'd2, 1'b0);
        send_tile(4'd1, 1'b1);
        in_valid = 1'b0;
        wait_outs(base + 1);
        repeat (4) @(posedge clk);
        #1;

        check("unexpected_outs", 32'(unexpected), 32'd0);
        check("exp_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_dot_engine.md
# conv_dot_engine

Parametrised, fully pipelined multi-channel dot-product engine for the convolution datapath. It holds a loadable CH×K weight set in place of hard-wired weights, and accepts one CH×K input tile per cycle. It accumulates a group of up to MAX_BEATS tiles, marked by `in_last`, and emits one unsigned sum per group. It sits between the IFM tile fetcher and the OFM writer.

## Interface
- `CH`, default 2: input channels per tile.
- `K`, default 16: elements per channel per tile (4×4 window).
- `DW`, default 4: unsigned IFM element width.
- `WW`, default 4: unsigned weight width.
- `MAX_BEATS`, default 4: tiles per group guaranteed overflow-free.
- Derived, not overridable: `OW = DW+WW+clog2(CH*K)+clog2(MAX_BEATS)`, which is 15 at the defaults.
- Clock and reset (already decided): reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `w_valid`, in, 1: weight beat offered.
- `w_ready`, out, 1: weight beat accepted when `w_valid && w_ready`.
- `w_data`, in, K*WW: one channel's weights; element e is at bits [e*WW +: WW].
- `in_valid`, in, 1: tile offered.
- `in_ready`, out, 1: tile accepted when `in_valid && in_ready`.
- `in_last`, in, 1: the tile being offered closes the group.
- `in_data`, in, CH*K*DW: tile; element (c,e) is at bits [(c*K+e)*DW +: DW].
- `out_valid`, out, 1: single-cycle result strobe.
- `out_ofm`, out, OW: group sum; 0 whenever `out_valid` is low.
- `out_sat`, out, 1: the group saturated. Present only with the `CONV_SAT_EN` macro.

## Operation
- FSM states: W_EMPTY (reset state), W_LOAD, READY, ACCUM.
- Weight load:
  - The weight beats fill channels 0..CH-1 in order, using a beat index counter that wraps at CH-1.
  - The beat that completes channel CH-1 moves the FSM to READY.
  - An accepted weight beat in READY restarts loading at channel 0 (state W_LOAD). The old weights are no longer valid.
- `w_ready`:
  - Equals 1 in W_EMPTY, W_LOAD and READY, provided that the pipeline holds no valid tile.
  - Equals 0 in ACCUM.
- `in_ready`: equals 1 in READY and ACCUM only. In W_EMPTY and W_LOAD no tile is accepted, so no output is produced.
- Tile transitions:
  - READY, tile accepted with `in_last=0`: go to ACCUM.
  - ACCUM, tile accepted with `in_last=1`: go to READY.
  - READY, tile accepted with `in_last=1`: single-tile group, stay in READY.
- Arithmetic: all unsigned.
  - Product width is DW+WW.
  - Channel sum width is DW+WW+clog2(K).
  - Tile sum and accumulator width is OW.
- Group accumulation:
  - The accumulator clears after the last tile of a group, so groups can run back-to-back with no idle cycle.
  - A group of more than MAX_BEATS tiles overflows. See Configuration.
- Reset mid-operation: every register clears at once and the FSM returns to W_EMPTY. Weights are lost and any open group is discarded without producing an output.

## Timing
- Reset values:
  - `out_valid`=0, `out_ofm`=0, `out_sat`=0.
  - `in_ready`=0, `w_ready`=1.
  - All weights 0; FSM in W_EMPTY.
- Pipeline, with E0 the edge at which a tile is accepted:
  - E0: input register captures the tile.
  - E1: products registered.
  - E2: per-channel sums registered.
  - E3: tile sum added to the accumulator. For a last tile, `out_ofm`/`out_valid` are registered at the same edge.
- Latency: 3 cycles from acceptance of the last tile to `out_valid`. Throughput is one tile per cycle.
- `out_valid` stays high for exactly one cycle per group.

## Configuration
- `CONV_SAT_EN` defined:
  - The accumulator clamps at 2^OW−1.
  - `out_sat`=1 is asserted with the result of any group that clamped.
- `CONV_SAT_EN` undefined:
  - The accumulator wraps modulo 2^OW.
  - The `out_sat` port does not exist.

## Structure
- Package `conv_pkg` holds:
  - the FSM state enum;
  - a `clog2` function;
  - the OW derivation function.
- Sub-module `conv_mac_lane`: one channel's K multipliers plus the registered adder tree (stages E1–E2). It is instantiated CH times.

## Test plan
All scenarios use the default parameters.
- Weight and data smoke test: load all weights = 1, send one tile of all 1s with `in_last=1` → `out_valid` exactly 3 cycles later with `out_ofm`=32.
- Maximum group: load all weights = 15, send 4 back-to-back tiles of all 15s, last on tile 4 → `out_ofm`=28800, one single-cycle strobe. An immediate next single-tile group of all 1s gives 480 in the following cycle.
- Overflow: same weights, 5 tiles of all 15s → 32767 with `out_sat`=1 under `CONV_SAT_EN`; 3232 without it.
- Weight handshake: offer `w_valid` during ACCUM → `w_ready`=0 and the weights are unchanged. Offer `in_valid` in W_EMPTY or mid-W_LOAD → `in_ready`=0 and no output.
- Reset: assert `rst_n`=0 after tile 2 of a 4-tile group → all outputs at reset values, state W_EMPTY, no `out_valid` after release until the weights are reloaded.
